stopwatch_ctrl: RTL and testbench

Control sequencer for the two-digit BCD stopwatch datapath (counter, lap register, display mux).
- Conditions the four raw push-buttons: synchronise, debounce, edge-detect.
- Arbitrates simultaneous presses and runs the IDLE/RUN/STOP state machine.
- Generates the 1-count tick and sequences lap capture and lap-display hold.
- Owns no display or BCD logic; the datapath consumes its enables and pulses.

---
 rtl/stopwatch_ctrl_pkg.sv | 37 +++
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl_btn_debounce.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 111 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Stopwatch control package.
// State encoding, button indices and press arbitration.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int BTN_CLEAR = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_START = 3;

    typedef struct packed {
        logic clr;
        logic stop;
        logic lap;
        logic start;
    } cmd_t;

    // Serve only the highest-priority press; the rest are dropped.
    function automatic cmd_t arbitrate(input logic [3:0] p);
        cmd_t c;
        c = '0;
        priority case (1'b1)
            p[BTN_CLEAR]: c.clr   = 1'b1;
            p[BTN_STOP]:  c.stop  = 1'b1;
            p[BTN_LAP]:   c.lap   = 1'b1;
            p[BTN_START]: c.start = 1'b1;
            default:      c       = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle.
// Raw buttons in, datapath enables and pulses out.
interface stopwatch_ctrl_if;
    logic [3:0] btn_in;
    logic       tick_o;
    logic       count_en_o;
    logic       clear_o;
    logic       lap_capture_o;
    logic       show_lap_o;
    logic [1:0] state_o;

    modport master (
        output btn_in,
        input  tick_o, count_en_o, clear_o,
        input  lap_capture_o, show_lap_o, state_o
    );

    modport slave (
        input  btn_in,
        output tick_o, count_en_o, clear_o,
        output lap_capture_o, show_lap_o, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Single push-button conditioner.
// Two-flop sync, stability counter, registered rising-edge press.
module btn_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d, lvl_dly_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level changes only after the synced input differs long enough.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            lvl_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, debounce state and press edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            press_q   <= lvl_q & ~lvl_dly_q;
        end
    end

    assign level = lvl_q;
    assign press = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer.
// Button conditioning, arbitration, run FSM, tick and lap hold.
module stopwatch_ctrl #(
    parameter int DIV        = 1200000,
    parameter int DEB_CYCLES = 65536,
    parameter int LAP_TICKS  = 20
) (
    input logic            clk,
    input logic            rst_n,
    stopwatch_ctrl_if.slave bus
);
    import stopwatch_pkg::*;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = $clog2(LAP_TICKS + 1);

    logic [3:0]    press;
    logic [3:0]    btn_lvl_unused;
    cmd_t          cmd;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q;
    state_t        state_q, state_d;
    logic [LW-1:0] lap_q, lap_d;
    logic          clr_q, clr_d;
    logic          cap_q, cap_d;
    logic          show_q, show_d;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn_in[i]),
            .level (btn_lvl_unused[i]),
            .press (press[i])
        );
    end

    assign cmd = arbitrate(press);

    // Free-running prescaler; wraps exactly at DIV-1.
    assign pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);

    // Prescaler and registered tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_q == PW'(DIV - 1));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; clear overrides from any state.
    always_comb begin
        state_d = state_q;
        if (cmd.clr) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (cmd.start) state_d = ST_RUN;
                ST_RUN:  if (cmd.stop)  state_d = ST_STOP;
                ST_STOP: if (cmd.start) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Command pulses and lap timer; a reload beats a same-cycle tick.
    always_comb begin
        clr_d = cmd.clr;
        cap_d = cmd.lap && (state_q != ST_IDLE);
        lap_d = lap_q;
        if (clr_d) begin
            lap_d = '0;
        end else if (cap_d) begin
            lap_d = LW'(LAP_TICKS);
        end else if (tick_q && (lap_q != '0)) begin
            lap_d = lap_q - LW'(1);
        end
        show_d = (lap_d != '0);
    end

    // Registered command outputs and lap hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q  <= 1'b0;
            cap_q  <= 1'b0;
            lap_q  <= '0;
            show_q <= 1'b0;
        end else begin
            clr_q  <= clr_d;
            cap_q  <= cap_d;
            lap_q  <= lap_d;
            show_q <= show_d;
        end
    end

    assign bus.tick_o        = tick_q;
    assign bus.count_en_o    = tick_q & (state_q == ST_RUN);
    assign bus.clear_o       = clr_q;
    assign bus.lap_capture_o = cap_q;
    assign bus.show_lap_o    = show_q;
    assign bus.state_o       = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl.
// DIV=4, DEB_CYCLES=3, LAP_TICKS=2; n counts edges since reset release.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n = 0;
    int   tests = 0;
    int   errs = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .DIV        (4),
        .DEB_CYCLES (3),
        .LAP_TICKS  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic obs(input logic [1:0] st, input bit cen, input bit cap,
                       input bit shw, input bit clr);
        chk("state", bus.state_o, st);
        chk("count_en", bus.count_en_o, cen);
        chk("lap_cap", bus.lap_capture_o, cap);
        chk("show_lap", bus.show_lap_o, shw);
        chk("clear", bus.clear_o, clr);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog n=%0d got=timeout exp=finish", n);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        bus.btn_in = 4'h0;
        #20;
        chk("rst_tick", bus.tick_o, 0);
        obs(ST_IDLE, 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Bounce: start toggles every 2 cycles, never debounces.
        for (int i = 0; i < 30; i++) begin
            if (i < 20) bus.btn_in[BTN_START] = ((i % 4) < 2);
            step();
            obs(ST_IDLE, 0, 0, 0, 0);
            chk("tick", bus.tick_o, (n % 4) == 0);
        end

        // Start: edge set at n=32, RUN from n=39.
        while (n < 32) step();
        bus.btn_in[BTN_START] = 1'b1;
        do begin
            step();
            obs((n >= 39) ? ST_RUN : ST_IDLE,
                ((n % 4) == 0) && (n >= 39), 0, 0, 0);
            chk("tick", bus.tick_o, (n % 4) == 0);
            if (n == 42) bus.btn_in[BTN_START] = 1'b0;
        end while (n < 50);

        // Single lap: capture at 58, hold drops after 2nd tick at 65.
        while (n < 51) step();
        bus.btn_in[BTN_LAP] = 1'b1;
        do begin
            step();
            obs(ST_RUN, (n % 4) == 0, n == 58, (n >= 58) && (n <= 64), 0);
            if (n == 55) bus.btn_in[BTN_LAP] = 1'b0;
        end while (n < 70);

        // Double lap: reload at 85 coincides with a tick and wins.
        while (n < 71) step();
        bus.btn_in[BTN_LAP] = 1'b1;
        do begin
            step();
            obs(ST_RUN, (n % 4) == 0, (n == 78) || (n == 85),
                (n >= 78) && (n <= 92), 0);
            if (n == 75) bus.btn_in[BTN_LAP] = 1'b0;
            if (n == 78) bus.btn_in[BTN_LAP] = 1'b1;
            if (n == 82) bus.btn_in[BTN_LAP] = 1'b0;
        end while (n < 96);

        // Stop and lap together: stop wins; tick at 108 still counts.
        while (n < 102) step();
        bus.btn_in[BTN_STOP] = 1'b1;
        bus.btn_in[BTN_LAP]  = 1'b1;
        do begin
            step();
            obs((n >= 109) ? ST_STOP : ST_RUN,
                ((n % 4) == 0) && (n < 109), 0, 0, 0);
            if (n == 106) begin
                bus.btn_in[BTN_STOP] = 1'b0;
                bus.btn_in[BTN_LAP]  = 1'b0;
            end
        end while (n < 118);

        // Lap in STOP, then clear while the hold is active.
        while (n < 120) step();
        bus.btn_in[BTN_LAP] = 1'b1;
        do begin
            step();
            obs((n >= 130) ? ST_IDLE : ST_STOP, 0, n == 127,
                (n >= 127) && (n <= 129), n == 130);
            if (n == 123) bus.btn_in[BTN_CLEAR] = 1'b1;
            if (n == 124) bus.btn_in[BTN_LAP] = 1'b0;
            if (n == 127) bus.btn_in[BTN_CLEAR] = 1'b0;
        end while (n < 140);

        // Lap in IDLE is ignored.
        while (n < 141) step();
        bus.btn_in[BTN_LAP] = 1'b1;
        do begin
            step();
            obs(ST_IDLE, 0, 0, 0, 0);
            if (n == 145) bus.btn_in[BTN_LAP] = 1'b0;
        end while (n < 155);

        // RUN with lap hold, then async reset between edges.
        while (n < 160) step();
        bus.btn_in[BTN_START] = 1'b1;
        do begin
            step();
            obs((n >= 167) ? ST_RUN : ST_IDLE,
                ((n % 4) == 0) && (n >= 167), n == 177, n >= 177, 0);
            if (n == 164) bus.btn_in[BTN_START] = 1'b0;
            if (n == 170) bus.btn_in[BTN_LAP] = 1'b1;
            if (n == 174) bus.btn_in[BTN_LAP] = 1'b0;
        end while (n < 180);
        chk("pre_rst_tick", bus.tick_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", bus.tick_o, 0);
        obs(ST_IDLE, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_tick", bus.tick_o, n == 4);
            chk("post_rst_state", bus.state_o, ST_IDLE);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
